// File: rtl/mcdf_reg_bank.sv
// mcdf_reg_bank -- control/status register bank for the MCDF formatter.
//
// Per channel i (0..CH_NUM-1):
//   CTRL[i] @ 0x00+4*i  R/W  bit0 en, bits[2:1] prio, bits[5:3] len, rest reads 0
//   STAT[i] @ 0x20+4*i  RO   zero-extended cmd_fifo_slack[i]
//   IRQ     @ 0x40           only when MCDF_SLACK_IRQ_EN is defined:
//                            bits[CH_NUM-1:0] sticky flags (W1C),
//                            bits[CH_NUM+7:8] interrupt mask (R/W)
//
// Command protocol (one-hot FSM IDLE/WR/RD_PRE/RD):
//   a write commits on every edge where cmd=WR moves the FSM into WR;
//   a read latches the address entering RD_PRE, loads cmd_data_out when
//   leaving it, and strobes cmd_rd_valid during RD.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd                 00 IDLE, 01 WR, 11 RD, 10 treated as IDLE
//   cmd_addr            byte address
//   cmd_data_in         write data
//   cmd_fifo_slack      packed slack, channel i at [i*SLACK_W +: SLACK_W]
//   cmd_data_out        registered read data
//   cmd_rd_valid        one-cycle strobe, cmd_data_out valid
//   cmd_err             one-cycle strobe, illegal access
//   cmd_slave_en        per-channel enables
//   cmd_fifo_priority   packed 2-bit priorities
//   cmd_fifo_length     packed 3-bit length codes
//   cmd_irq             registered interrupt (0 unless MCDF_SLACK_IRQ_EN)
module mcdf_reg_bank #(
  parameter int CH_NUM  = 3,
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int SLACK_W = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  cmd,
  input  logic [AW-1:0]               cmd_addr,
  input  logic [DW-1:0]               cmd_data_in,
  input  logic [CH_NUM*SLACK_W-1:0]   cmd_fifo_slack,
  output logic [DW-1:0]               cmd_data_out,
  output logic                        cmd_rd_valid,
  output logic                        cmd_err,
  output logic [CH_NUM-1:0]           cmd_slave_en,
  output logic [CH_NUM*2-1:0]         cmd_fifo_priority,
  output logic [CH_NUM*3-1:0]         cmd_fifo_length,
  output logic                        cmd_irq
);

  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [1:0] CMD_RD = 2'b11;

`ifdef MCDF_SLACK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_WR     = 4'b0010,
    S_RD_PRE = 4'b0100,
    S_RD     = 4'b1000
  } state_t;

  typedef struct packed {
    logic       ctrl;
    logic       stat;
    logic       irq;
    logic [2:0] idx;
  } dec_t;

  // Classify an address; anything not flagged is illegal.
  function automatic dec_t decode(input logic [AW-1:0] a);
    dec_t d;
    d     = '0;
    d.idx = a[4:2];
    if (a[1:0] == 2'b00) begin
      d.ctrl = (a[AW-1:5] == '0) && (int'(a[4:2]) < CH_NUM);
      d.stat = (a[AW-1:6] == '0) && a[5] && (int'(a[4:2]) < CH_NUM);
      d.irq  = IRQ_EN && (a == AW'('h40));
    end
    return d;
  endfunction

  state_t              state_q, state_d;
  logic [AW-1:0]       rd_addr_q;
  logic [CH_NUM-1:0]   en_q;
  logic [CH_NUM*2-1:0] prio_q;
  logic [CH_NUM*3-1:0] len_q;
  logic [DW-1:0]       rd_word;
  logic [DW-1:0]       irq_word;
  dec_t                wdec, rdec;
  logic                wr_fire, wr_ctrl, wr_illegal, rd_illegal;

  // Only the low control bits and (optionally) the IRQ fields are stored.
  logic unused_data;
  assign unused_data = ^cmd_data_in;

  assign wdec       = decode(cmd_addr);
  assign rdec       = decode(rd_addr_q);
  assign wr_fire    = (state_q != S_RD_PRE) && (cmd == CMD_WR);
  assign wr_ctrl    = wr_fire && wdec.ctrl;
  assign wr_illegal = !(wdec.ctrl || wdec.irq);
  assign rd_illegal = !(rdec.ctrl || rdec.stat || rdec.irq);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = S_IDLE;
    if (state_q == S_RD_PRE) begin
      state_d = S_RD;                   // cmd ignored while the mux settles
    end else begin
      case (cmd)
        CMD_WR:  state_d = S_WR;
        CMD_RD:  state_d = S_RD_PRE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmd_rd_valid = (state_q == S_RD);
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      prio_q <= '1;
      len_q  <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (wr_ctrl && (wdec.idx == 3'(i))) begin
          en_q[i]          <= cmd_data_in[0];
          prio_q[i*2 +: 2] <= cmd_data_in[2:1];
          len_q[i*3 +: 3]  <= cmd_data_in[5:3];
        end
      end
    end
  end

  assign cmd_slave_en      = en_q;
  assign cmd_fifo_priority = prio_q;
  assign cmd_fifo_length   = len_q;

  // ---------------- read path ----------------
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (rdec.ctrl && (rdec.idx == 3'(i)))
        rd_word = DW'({len_q[i*3 +: 3], prio_q[i*2 +: 2], en_q[i]});
      if (rdec.stat && (rdec.idx == 3'(i)))
        rd_word = DW'(cmd_fifo_slack[i*SLACK_W +: SLACK_W]);
    end
    if (rdec.irq) rd_word = irq_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q    <= '0;
      cmd_data_out <= '0;
      cmd_err      <= 1'b0;
    end else begin
      if (state_d == S_RD_PRE) rd_addr_q <= cmd_addr;
      if (state_q == S_RD_PRE) cmd_data_out <= rd_illegal ? '0 : rd_word;
      // Read errors line up with the RD cycle, write errors with the
      // cycle after the write edge.
      cmd_err <= ((state_q == S_RD_PRE) && rd_illegal) || (wr_fire && wr_illegal);
    end
  end

  // ---------------- optional slack interrupt ----------------
`ifdef MCDF_SLACK_IRQ_EN
  logic [CH_NUM-1:0] flag_q, mask_q, slack_nz, slack_nz_q, irq_set, irq_clr;
  logic              wr_irq, irq_q;

  assign wr_irq = wr_fire && wdec.irq;

  always_comb begin
    slack_nz = '0;
    irq_set  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      slack_nz[i] = |cmd_fifo_slack[i*SLACK_W +: SLACK_W];
      irq_set[i]  = en_q[i] && slack_nz_q[i] && !slack_nz[i];
    end
    irq_clr = wr_irq ? cmd_data_in[CH_NUM-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slack_nz_q <= '0;
      flag_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      slack_nz_q <= slack_nz;
      flag_q     <= irq_set | (flag_q & ~irq_clr);   // set beats clear
      if (wr_irq) mask_q <= cmd_data_in[8 +: CH_NUM];
      irq_q      <= |(flag_q & mask_q);
    end
  end

  always_comb begin
    irq_word               = '0;
    irq_word[CH_NUM-1:0]   = flag_q;
    irq_word[8 +: CH_NUM]  = mask_q;
  end

  assign cmd_irq = irq_q;
`else
  assign irq_word = '0;
  assign cmd_irq  = 1'b0;
`endif

endmodule
